// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Frame layout: LEN_HI, LEN_LO, N big-endian words, one XOR checksum byte.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  localparam int LEN_BYTES   = 2;
  localparam int WORD_BYTES  = 4;
  localparam int CKSUM_BYTES = 1;

  // Total frame length in bytes for a given word count.
  function automatic int frame_bytes(input int n_words);
    return LEN_BYTES + WORD_BYTES * n_words + CKSUM_BYTES;
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Collects stream bytes MSB-first into 32-bit words; word/word_valid are
// combinational so the caller can register them in the same cycle as the 4th byte.
module loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] shreg;
  logic [1:0]  byte_cnt;

  assign word       = {shreg, byte_data};
  assign word_valid = byte_valid && (byte_cnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (byte_valid) begin
      shreg    <= word[23:0];
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into imem and holds
// the core in reset until a complete image has been verified.
//
// state  | meaning
// HDR_HI | waiting for word-count high byte
// HDR_LO | waiting for word-count low byte; range check
// DATA   | receiving data bytes, one imem write per 4 bytes
// CHECK  | waiting for checksum byte
// DONE   | image good, core released
// ERROR  | bad length or checksum, core held in reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [31:0] CAP   = 32'(DEPTH - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t      state;
  logic [15:0] len;
  logic [15:0] word_cnt;
  logic [7:0]  cksum;

  logic        xfer;
  logic [15:0] len_rx;
  logic        len_too_big;
  logic        last_word;
  logic [31:0] packed_word;
  logic        word_valid;

  // restart wins over a coincident byte, so the byte is never counted as transferred
  assign xfer        = rx_valid && rx_ready && !restart;
  assign len_rx      = {len[15:8], rx_data};
  assign len_too_big = {16'h0, len_rx} > CAP;
  assign last_word   = (word_cnt + 16'd1) == len;

  loader_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .byte_valid (xfer && (state == DATA)),
    .byte_data  (rx_data),
    .word       (packed_word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HDR_HI;
      len        <= '0;
      word_cnt   <= '0;
      cksum      <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (restart) begin
        state     <= HDR_HI;
        len       <= '0;
        word_cnt  <= '0;
        cksum     <= '0;
        rx_ready  <= 1'b1;
        cpu_reset <= 1'b1;
        done      <= 1'b0;
        error     <= 1'b0;
      end else begin
        case (state)
          HDR_HI: begin
            rx_ready <= 1'b1;
            if (xfer) begin
              len[15:8] <= rx_data;
              cksum     <= cksum ^ rx_data;
              state     <= HDR_LO;
            end
          end
          HDR_LO: begin
            rx_ready <= 1'b1;
            if (xfer) begin
              len   <= len_rx;
              cksum <= cksum ^ rx_data;
              if (len_too_big) begin
                state    <= ERROR;
                error    <= 1'b1;
                rx_ready <= 1'b0;
              end else if (len_rx == 16'h0) begin
                state <= CHECK;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            rx_ready <= 1'b1;
            if (xfer) begin
              cksum <= cksum ^ rx_data;
              if (word_valid) begin
                imem_we    <= 1'b1;
                imem_addr  <= BASE + ADDR_W'(word_cnt);
                imem_wdata <= packed_word;
                word_cnt   <= word_cnt + 16'd1;
                if (last_word) state <= CHECK;
              end
            end
          end
          CHECK: begin
            rx_ready <= 1'b1;
            if (xfer) begin
              rx_ready <= 1'b0;
              if (rx_data == cksum) begin
                state     <= DONE;
                done      <= 1'b1;
                cpu_reset <= 1'b0;
              end else begin
                state <= ERROR;
                error <= 1'b1;
              end
            end
          end
          default: rx_ready <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected imem writes go into a queue that a
// negedge monitor drains; status outputs are checked directly after each frame.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        restart;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [39:0] exp_q[$];
  logic [31:0] mem [0:255];

  imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .restart    (restart),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we) begin
      logic [39:0] e;
      wr_count++;
      mem[imem_addr] = imem_wdata;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0h data=%08h, expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("FAIL write got addr=%0h data=%08h, expected addr=%0h data=%08h",
                   imem_addr, imem_wdata, e[39:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Called and returns just after a rising edge.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    logic ok;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk); #1;
      n++;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte %02h not accepted within 50 cycles", b);
    end
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input logic gaps);
    foreach (bytes[i]) send(bytes[i], gaps ? int'($urandom_range(1, 5)) : 0);
  endtask

  task automatic pulse_restart(input logic with_byte);
    restart  = 1'b1;
    rx_valid = with_byte;
    rx_data  = 8'h77;
    @(posedge clk); #1;
    restart  = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic expect_prog3();
    expect_write(8'd0, 32'h20080005);
    expect_write(8'd1, 32'h20090003);
    expect_write(8'd2, 32'h01095020);
  endtask

  logic [7:0] prog3[$];
  int w0;

  initial begin
    prog3 = '{8'h00, 8'h03, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h03,
              8'h01, 8'h09, 8'h50, 8'h20, 8'h7C};
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; restart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rx_ready_after_rst", rx_ready, 1);

    // clean load, no gaps
    expect_prog3();
    send_frame(prog3, 1'b0);
    chk("t1_done", done, 1);
    chk("t1_cpu_reset", cpu_reset, 0);
    chk("t1_error", error, 0);
    chk("t1_rx_ready", rx_ready, 0);
    chk("t1_mem0", mem[0], 32'h20080005);
    chk("t1_mem1", mem[1], 32'h20090003);
    chk("t1_mem2", mem[2], 32'h01095020);
    pulse_restart(1'b0);
    chk("t1_restart_done", done, 0);
    chk("t1_restart_cpu_reset", cpu_reset, 1);

    // same image with idle gaps
    expect_prog3();
    send_frame(prog3, 1'b1);
    chk("t2_done", done, 1);
    chk("t2_cpu_reset", cpu_reset, 0);
    pulse_restart(1'b0);

    // corrupted checksum
    expect_prog3();
    prog3[14] = 8'h7D;
    w0 = wr_count;
    send_frame(prog3, 1'b0);
    chk("t3_writes", wr_count - w0, 3);
    chk("t3_error", error, 1);
    chk("t3_done", done, 0);
    chk("t3_cpu_reset", cpu_reset, 1);
    pulse_restart(1'b0);
    chk("t3_restart_error", error, 0);

    // length exceeds capacity
    w0 = wr_count;
    send(8'h01, 0);
    send(8'h01, 0);
    chk("t4_error", error, 1);
    chk("t4_rx_ready", rx_ready, 0);
    repeat (3) @(posedge clk); #1;
    chk("t4_writes", wr_count - w0, 0);
    pulse_restart(1'b0);

    // empty image
    w0 = wr_count;
    send_frame('{8'h00, 8'h00, 8'h00}, 1'b0);
    chk("t5_done", done, 1);
    chk("t5_writes", wr_count - w0, 0);
    pulse_restart(1'b0);
    chk("t5_restart_done", done, 0);
    chk("t5_restart_cpu_reset", cpu_reset, 1);
    chk("t5_restart_rx_ready", rx_ready, 1);

    // abort mid-DATA, restart with a coincident byte that must be dropped
    expect_write(8'd0, 32'h11223344);
    send_frame('{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 1'b0);
    pulse_restart(1'b1);
    expect_write(8'd0, 32'hDEADBEEF);
    w0 = wr_count;
    send_frame('{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23}, 1'b0);
    chk("t6_writes", wr_count - w0, 1);
    chk("t6_done", done, 1);
    chk("t6_error", error, 0);
    pulse_restart(1'b0);

    // async reset mid-DATA
    expect_write(8'd0, 32'h01020304);
    expect_write(8'd1, 32'h05060708);
    send_frame('{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09},
               1'b0);
    chk("t7_addr_before", imem_addr, 1);
    reset = 1'b1;
    #1;
    chk("t7_rx_ready", rx_ready, 0);
    chk("t7_imem_we", imem_we, 0);
    chk("t7_imem_addr", imem_addr, 0);
    chk("t7_imem_wdata", imem_wdata, 0);
    chk("t7_cpu_reset", cpu_reset, 1);
    chk("t7_done", done, 0);
    chk("t7_error", error, 0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
